prim_arb_8x1: RTL and testbench
===============================

PRIM_ARB_8X1 -- requirements
Module: prim_arb_8x1

Interface
REQ-001 Parameter PTR_RST, default 0, SHALL be the requester index (0..7) that holds highest priority after reset.
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  SHALL be the reset: synchronous and active-high.
REQ-004 i_req  input  8  SHALL carry per-requester request flags, bit n = requester n.
REQ-005 i_ready  input  1  SHALL be the downstream accept; a handshake occurs when o_valid and i_ready are both 1 at a rising edge.
REQ-006 i_lock  input  1  SHALL be the grant-lock request, present only when PRIM_ARB_LOCK_EN is defined.
REQ-007 o_sel  output  3  SHALL carry the binary index of the granted requester, intended to drive the i_sel input of an 8:1 mux.
REQ-008 o_gnt  output  8  SHALL be the one-hot grant, equal to 1 shifted left by o_sel while o_valid=1, else all zero.
REQ-009 o_valid  output  1  SHALL indicate that o_sel/o_gnt hold a valid grant.

Function
REQ-010 The block SHALL implement two states: IDLE (o_valid=0) and GRANT (o_valid=1); all outputs SHALL be registered.
REQ-011 Priority pointer ptr (3 bits) SHALL define the search order ptr, ptr+1, ..., ptr+7, all modulo 8; the winner is the first index in that order with i_req set.
REQ-012 IDLE: if i_req != 0, the block SHALL load the winner into o_sel, set o_gnt and o_valid, and enter GRANT at the next edge (latency 1 cycle from request to o_valid).
REQ-013 IDLE with i_req == 0: the block SHALL remain in IDLE with o_gnt=0 and o_sel unchanged.
REQ-014 GRANT without handshake: o_sel, o_gnt and o_valid SHALL hold stable; the grant SHALL NOT be revoked if i_req[o_sel] drops.
REQ-015 GRANT with handshake: ptr SHALL become o_sel+1 modulo 8 (7 wraps to 0).
REQ-016 GRANT with handshake: the next winner SHALL be searched over the current i_req using the updated ptr; if one exists, it SHALL be loaded and the block SHALL stay in GRANT, giving back-to-back grants with no bubble.
REQ-017 GRANT with handshake and i_req == 0: the block SHALL return to IDLE, with o_valid=0 and o_gnt=0 at the next edge.
REQ-018 A requester that stays asserted SHALL be granted within at most 8 handshakes (starvation-free).
REQ-019 Changes on i_req in the handshake cycle SHALL be sampled in that same cycle.

Reset
REQ-020 While i_rst=1 at an edge: state SHALL become IDLE, o_valid=0, o_gnt=8'h00, o_sel=3'd0, ptr=PTR_RST.
REQ-021 Reset during GRANT SHALL discard the pending grant with no handshake implied, and reset SHALL override i_ready and i_req in the same cycle.
REQ-022 In the first cycle after reset deasserts, the block SHALL arbitrate normally from ptr=PTR_RST.

Configuration
REQ-023 Macro PRIM_ARB_LOCK_EN SHALL select the grant-lock feature at compile time.
REQ-024 With PRIM_ARB_LOCK_EN defined: on a handshake with i_lock=1 and i_req[o_sel]=1, the same index SHALL be re-granted and ptr SHALL NOT advance.
REQ-025 With PRIM_ARB_LOCK_EN defined: on a handshake with i_lock=1 but i_req[o_sel]=0, the block SHALL follow REQ-015 to REQ-017.
REQ-026 Without PRIM_ARB_LOCK_EN: the i_lock port SHALL be absent and behaviour SHALL be exactly REQ-010 to REQ-019.

Verification
REQ-027 Reset, then i_req=8'h81, i_ready=1 held -> o_sel sequence 0,7,0,7 with o_valid=1 continuously from cycle 1 after request.
REQ-028 ptr=5, i_req=8'h09 -> o_sel=0 (wrap search); after handshake, o_sel=3, then ptr=4.
REQ-029 Grant o_sel=2, i_ready=0 for 4 cycles while i_req[2] drops to 0 -> o_sel=2 and o_gnt=8'h04 stable; after handshake with i_req=0, o_valid=0.
REQ-030 i_req=8'hFF, i_ready=1 -> o_sel 0,1,...,7,0 with o_gnt always one-hot and matching o_sel.
REQ-031 Assert i_rst mid-GRANT (o_sel=6) with i_ready=1 -> next edge: o_valid=0, o_gnt=0, o_sel=0, and the next grant follows PTR_RST order.
REQ-032 PRIM_ARB_LOCK_EN defined, i_req=8'h30, i_lock=1 for 3 handshakes -> o_sel=4 three times, then o_sel=5 after i_lock=0.

Source files
------------

// File: rtl/prim_arb_8x1.sv
// Round-robin 8:1 arbiter with registered valid/ready grant output.
// Optional grant lock is compiled in with `define PRIM_ARB_LOCK_EN.
//
// state | meaning
// IDLE  | no grant outstanding, o_valid=0
// GRANT | o_sel/o_gnt hold a grant awaiting handshake, o_valid=1
module prim_arb_8x1 #(
  parameter logic [2:0] PTR_RST = 3'd0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_req,
  input  logic       i_ready,
`ifdef PRIM_ARB_LOCK_EN
  input  logic       i_lock,
`endif
  output logic [2:0] o_sel,
  output logic [7:0] o_gnt,
  output logic       o_valid
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;

  logic       hs;
  logic       lock_hold;
  logic [2:0] base;
  logic [2:0] idx;
  logic [2:0] win;
  logic       found;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      sel_q   <= 3'd0;
      gnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  // After a handshake the search already starts past the index just served,
  // so back-to-back grants need no extra cycle.
  always_comb begin
    hs        = (state_q == GRANT) && i_ready;
    lock_hold = 1'b0;
`ifdef PRIM_ARB_LOCK_EN
    lock_hold = hs && i_lock && i_req[sel_q];
`endif
    base  = hs ? sel_q + 3'd1 : ptr_q;
    found = 1'b0;
    win   = 3'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = base + 3'(i);
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = win;
          gnt_d   = 8'b1 << win;
          state_d = GRANT;
        end else begin
          gnt_d = 8'h00;
        end
      end
      GRANT: begin
        if (lock_hold) begin
          state_d = GRANT;
        end else if (hs) begin
          ptr_d = base;
          if (found) begin
            sel_d = win;
            gnt_d = 8'b1 << win;
          end else begin
            gnt_d   = 8'h00;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_sel   = sel_q;
  assign o_gnt   = gnt_q;
  assign o_valid = (state_q == GRANT);

endmodule

// File: tb/tb_prim_arb_8x1.sv
// Directed self-checking bench for prim_arb_8x1 (PTR_RST=0).
// Lock steps are included only when PRIM_ARB_LOCK_EN is defined.
module tb_prim_arb_8x1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       ready;
  logic       lock;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prim_arb_8x1 #(.PTR_RST(3'd0)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_ready (ready),
`ifdef PRIM_ARB_LOCK_EN
    .i_lock  (lock),
`endif
    .o_sel   (sel),
    .o_gnt   (gnt),
    .o_valid (valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [2:0] exp_sel);
    chk({tag, "_valid"}, {7'd0, valid}, 8'h01);
    chk({tag, "_sel"}, {5'd0, sel}, {5'd0, exp_sel});
    chk({tag, "_gnt"}, gnt, 8'h01 << exp_sel);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {7'd0, valid}, 8'h00);
    chk({tag, "_gnt"}, gnt, 8'h00);
  endtask

  initial begin
    logic [2:0] seq [0:8];
    rst = 1'b1; req = 8'h00; ready = 1'b0; lock = 1'b0;
    step(); step();
    chk_idle("rst");
    chk("rst_sel", {5'd0, sel}, 8'h00);

    // alternating 0/7 with ready held high, no bubble
    rst = 1'b0; req = 8'h81; ready = 1'b1;
    step(); chk_grant("alt0", 3'd0);
    step(); chk_grant("alt1", 3'd7);
    step(); chk_grant("alt2", 3'd0);
    step(); chk_grant("alt3", 3'd7);
    req = 8'h00;
    step(); chk_idle("alt_end");

    // drive ptr to 5 by serving requester 4
    req = 8'h10; ready = 1'b0;
    step(); chk_grant("p5_g4", 3'd4);
    req = 8'h00; ready = 1'b1;
    step(); chk_idle("p5_idle");
    req = 8'h09; ready = 1'b0;
    step(); chk_grant("wrap0", 3'd0);
    ready = 1'b1;
    step(); chk_grant("wrap3", 3'd3);
    req = 8'h00;
    step(); chk_idle("wrap_idle");
    req = 8'hFF; ready = 1'b0;
    step(); chk_grant("ptr4", 3'd4);

    // hold grant 2 while its request drops; ptr is 5 after this handshake
    req = 8'h00; ready = 1'b1;
    step(); chk_idle("h_pre");
    req = 8'h04; ready = 1'b0;
    step(); chk_grant("hold_g", 3'd2);
    req = 8'h00;
    for (int k = 0; k < 4; k++) begin
      step(); chk_grant("hold", 3'd2);
    end
    ready = 1'b1;
    step(); chk_idle("hold_rel");

    // full rotation from reset
    rst = 1'b1; req = 8'h00;
    step();
    rst = 1'b0; req = 8'hFF; ready = 1'b1;
    seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    for (int k = 0; k < 9; k++) begin
      step(); chk_grant("rot", seq[k]);
    end

    // request change seen in handshake cycle, then reset mid-grant
    req = 8'h40;
    step(); chk_grant("pre_rst6", 3'd6);
    rst = 1'b1; req = 8'hFF; ready = 1'b1;
    step(); chk_idle("mid_rst");
    chk("mid_rst_sel", {5'd0, sel}, 8'h00);
    rst = 1'b0; req = 8'h81; ready = 1'b0;
    step(); chk_grant("post_rst", 3'd0);

`ifdef PRIM_ARB_LOCK_EN
    req = 8'h00; ready = 1'b1;
    step(); chk_idle("lk_pre");
    req = 8'h30; ready = 1'b0;
    step(); chk_grant("lk_g", 3'd4);
    ready = 1'b1; lock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk_grant("lk_hold", 3'd4);
    end
    lock = 1'b0;
    step(); chk_grant("lk_rel", 3'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
